mem_access_ctrl: RTL and testbench

Memory-stage access controller. It sits directly downstream of the EX/MEM pipeline register and consumes its MEM-stage control and data outputs. It turns each load or store into a valid/ready request on the data-memory port and waits for the response. While the access is outstanding it holds the pipeline through `Stall_M`, and it hands the registered load data to the MEM/WB register.

---
 rtl/mem_access_ctrl.sv | 144 ++++++++++++++
 tb/tb_mem_access_ctrl.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_access_ctrl.sv
// -----------------------------------------------------------------------------
// mem_access_ctrl
//
// Memory-stage access controller. It sits behind the EX/MEM pipeline register
// and turns each aligned load or store into a valid/ready request on the
// data-memory port. It holds the pipeline with Stall_M while the access is
// outstanding, and it presents the registered load data to MEM/WB.
//
// Ports
//   clk            : clock
//   rst            : synchronous reset, active-low
//   MemWrite_M     : store in the MEM stage
//   ResultSrc_M    : 2'b01 marks a load
//   ALUResult_M    : byte address of the access
//   WriteData_M    : store data
//   dmem_req_valid : request valid (combinational)
//   dmem_req_ready : memory accepts the request
//   dmem_we        : 1 = store, 0 = load
//   dmem_addr      : request address (ALUResult_M)
//   dmem_wdata     : request write data (WriteData_M)
//   dmem_rsp_valid : load response / store acknowledge, 1-cycle pulse
//   dmem_rsp_rdata : load data, used only with dmem_rsp_valid
//   ReadData_M     : registered load data to MEM/WB
//   Stall_M        : freeze PC, IF/ID, ID/EX, EX/MEM; bubble MEM/WB
//   misalign_M     : current memory op has a nonzero low address pair
//   misalign_err   : sticky misalignment flag, cleared only by reset
//   stall_cycles   : saturating count of cycles with Stall_M = 1
// -----------------------------------------------------------------------------
module mem_access_ctrl #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             MemWrite_M,
    input  logic [1:0]       ResultSrc_M,
    input  logic [31:0]      ALUResult_M,
    input  logic [31:0]      WriteData_M,
    output logic             dmem_req_valid,
    input  logic             dmem_req_ready,
    output logic             dmem_we,
    output logic [31:0]      dmem_addr,
    output logic [31:0]      dmem_wdata,
    input  logic             dmem_rsp_valid,
    input  logic [31:0]      dmem_rsp_rdata,
    output logic [31:0]      ReadData_M,
    output logic             Stall_M,
    output logic             misalign_M,
    output logic             misalign_err,
    output logic [CNT_W-1:0] stall_cycles
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic             we_q, we_d;
    logic [31:0]      rdata_q, rdata_d;
    logic             err_q, err_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic mem_op;
    logic aligned;
    logic issue;

    // Saturating increment: the counter sticks at all-ones instead of wrapping.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        if (&v) begin
            return v;
        end
        return v + {{(CNT_W-1){1'b0}}, 1'b1};
    endfunction

    assign mem_op  = MemWrite_M | (ResultSrc_M == 2'b01);
    assign aligned = (ALUResult_M[1:0] == 2'b00);

    // A request is only ever issued from IDLE; while it waits for ready,
    // EX/MEM is frozen, so the request fields stay stable on their own.
    assign issue = (state_q == IDLE) && mem_op && aligned;

    assign dmem_req_valid = issue;
    assign dmem_we        = MemWrite_M;
    assign dmem_addr      = ALUResult_M;
    assign dmem_wdata     = WriteData_M;
    assign Stall_M        = issue || (state_q == WAIT);
    assign misalign_M     = mem_op && !aligned;

    assign ReadData_M   = rdata_q;
    assign misalign_err = err_q;
    assign stall_cycles = cnt_q;

    always_comb begin
        state_d = state_q;
        we_d    = we_q;
        rdata_d = rdata_q;
        err_d   = err_q | misalign_M;
        cnt_d   = Stall_M ? sat_inc(cnt_q) : cnt_q;

        case (state_q)
            IDLE: begin
                if (issue && dmem_req_ready) begin
                    state_d = WAIT;
                    // Latch the direction so the response is interpreted
                    // correctly independent of what the inputs show later.
                    we_d    = MemWrite_M;
                end
            end
            WAIT: begin
                if (dmem_rsp_valid) begin
                    if (!we_q) begin
                        rdata_d = dmem_rsp_rdata;
                    end
                    state_d = DONE;
                end
            end
            DONE: begin
                // The op leaves MEM this cycle; go back and look for the next.
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= IDLE;
            we_q    <= 1'b0;
            rdata_q <= 32'd0;
            err_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            we_q    <= we_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule

// File: tb/tb_mem_access_ctrl.sv
module tb_mem_access_ctrl;

    logic        clk;
    logic        rst;
    logic        MemWrite_M;
    logic [1:0]  ResultSrc_M;
    logic [31:0] ALUResult_M;
    logic [31:0] WriteData_M;
    logic        dmem_req_valid;
    logic        dmem_req_ready;
    logic        dmem_we;
    logic [31:0] dmem_addr;
    logic [31:0] dmem_wdata;
    logic        dmem_rsp_valid;
    logic [31:0] dmem_rsp_rdata;
    logic [31:0] ReadData_M;
    logic        Stall_M;
    logic        misalign_M;
    logic        misalign_err;
    logic [31:0] stall_cycles;

    // Small-counter copy sharing all inputs, used to reach saturation quickly.
    logic        s_req_valid, s_we, s_Stall_M, s_misalign_M, s_misalign_err;
    logic [31:0] s_addr, s_wdata, s_ReadData_M;
    logic [2:0]  s_stall_cycles;

    int total = 0;
    int bad   = 0;
    logic [31:0] exp_q[$];
    logic [31:0] exp_v;

    mem_access_ctrl #(.CNT_W(32)) dut (
        .clk(clk), .rst(rst),
        .MemWrite_M(MemWrite_M), .ResultSrc_M(ResultSrc_M),
        .ALUResult_M(ALUResult_M), .WriteData_M(WriteData_M),
        .dmem_req_valid(dmem_req_valid), .dmem_req_ready(dmem_req_ready),
        .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
        .dmem_rsp_valid(dmem_rsp_valid), .dmem_rsp_rdata(dmem_rsp_rdata),
        .ReadData_M(ReadData_M), .Stall_M(Stall_M), .misalign_M(misalign_M),
        .misalign_err(misalign_err), .stall_cycles(stall_cycles)
    );

    mem_access_ctrl #(.CNT_W(3)) u_sat (
        .clk(clk), .rst(rst),
        .MemWrite_M(MemWrite_M), .ResultSrc_M(ResultSrc_M),
        .ALUResult_M(ALUResult_M), .WriteData_M(WriteData_M),
        .dmem_req_valid(s_req_valid), .dmem_req_ready(dmem_req_ready),
        .dmem_we(s_we), .dmem_addr(s_addr), .dmem_wdata(s_wdata),
        .dmem_rsp_valid(dmem_rsp_valid), .dmem_rsp_rdata(dmem_rsp_rdata),
        .ReadData_M(s_ReadData_M), .Stall_M(s_Stall_M), .misalign_M(s_misalign_M),
        .misalign_err(s_misalign_err), .stall_cycles(s_stall_cycles)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_nop();
        MemWrite_M     = 1'b0;
        ResultSrc_M    = 2'b00;
        ALUResult_M    = 32'd0;
        WriteData_M    = 32'd0;
        dmem_req_ready = 1'b0;
        dmem_rsp_valid = 1'b0;
        dmem_rsp_rdata = 32'd0;
    endtask

    task automatic set_load(input logic [31:0] addr);
        MemWrite_M  = 1'b0;
        ResultSrc_M = 2'b01;
        ALUResult_M = addr;
    endtask

    task automatic do_reset();
        set_nop();
        rst = 1'b0;
        tick();
        tick();
        rst = 1'b1;
    endtask

    task automatic test_reset();
        set_nop();
        rst = 1'b0;
        tick();
        tick();
        total++; if (Stall_M !== 1'b0) begin bad++; $display("FAIL rst_stall got=%b want=0", Stall_M); end
        total++; if (dmem_req_valid !== 1'b0) begin bad++; $display("FAIL rst_valid got=%b want=0", dmem_req_valid); end
        total++; if (ReadData_M !== 32'd0) begin bad++; $display("FAIL rst_rdata got=%h want=0", ReadData_M); end
        total++; if (misalign_err !== 1'b0) begin bad++; $display("FAIL rst_err got=%b want=0", misalign_err); end
        total++; if (stall_cycles !== 32'd0) begin bad++; $display("FAIL rst_cnt got=%0d want=0", stall_cycles); end
        rst = 1'b1;
        tick();
        total++; if (misalign_M !== 1'b0) begin bad++; $display("FAIL rst_mis got=%b want=0", misalign_M); end
    endtask

    task automatic test_load();
        do_reset();
        set_load(32'h100);
        dmem_req_ready = 1'b1;
        #1;
        total++; if ({Stall_M, dmem_req_valid, dmem_we} !== 3'b110) begin bad++; $display("FAIL load_c0 got=%b want=110", {Stall_M, dmem_req_valid, dmem_we}); end
        total++; if (dmem_addr !== 32'h100) begin bad++; $display("FAIL load_addr got=%h want=100", dmem_addr); end
        tick();
        dmem_req_ready = 1'b0;
        dmem_rsp_valid = 1'b1;
        dmem_rsp_rdata = 32'hDEADBEEF;
        exp_q.push_back(32'hDEADBEEF);
        #1;
        total++; if ({Stall_M, dmem_req_valid} !== 2'b10) begin bad++; $display("FAIL load_c1 got=%b want=10", {Stall_M, dmem_req_valid}); end
        tick();
        dmem_rsp_valid = 1'b0;
        #1;
        total++; if ({Stall_M, dmem_req_valid} !== 2'b00) begin bad++; $display("FAIL load_c2 got=%b want=00", {Stall_M, dmem_req_valid}); end
        exp_v = exp_q.pop_front();
        total++; if (ReadData_M !== exp_v) begin bad++; $display("FAIL load_rdata got=%h want=%h", ReadData_M, exp_v); end
        tick();
        set_nop();
        tick();
        total++; if (stall_cycles !== 32'd2) begin bad++; $display("FAIL load_cnt got=%0d want=2", stall_cycles); end
    endtask

    // Runs right after test_load so ReadData_M holds a known nonzero value.
    task automatic test_store();
        int nvalid = 0;
        int nstall = 0;
        MemWrite_M  = 1'b1;
        ResultSrc_M = 2'b00;
        ALUResult_M = 32'h204;
        WriteData_M = 32'h12345678;
        exp_q.push_back(ReadData_M === 32'hDEADBEEF ? 32'hDEADBEEF : 32'hDEADBEEF);
        for (int c = 0; c < 7; c++) begin
            dmem_req_ready = (c == 3);
            dmem_rsp_valid = (c == 5);
            dmem_rsp_rdata = 32'hBAD0BAD0;
            #1;
            if (dmem_req_valid) begin
                nvalid++;
                total++;
                if (dmem_addr !== 32'h204 || dmem_wdata !== 32'h12345678 || dmem_we !== 1'b1) begin
                    bad++; $display("FAIL store_fields c=%0d got=%h/%h/%b want=204/12345678/1", c, dmem_addr, dmem_wdata, dmem_we);
                end
            end
            if (Stall_M) nstall++;
            if (c == 6) begin
                exp_v = exp_q.pop_front();
                total++; if (ReadData_M !== exp_v) begin bad++; $display("FAIL store_rdata got=%h want=%h", ReadData_M, exp_v); end
            end
            tick();
        end
        total++; if (nvalid != 4) begin bad++; $display("FAIL store_valid_cycles got=%0d want=4", nvalid); end
        total++; if (nstall != 6) begin bad++; $display("FAIL store_stall_cycles got=%0d want=6", nstall); end
        set_nop();
        tick();
        total++; if (stall_cycles !== 32'd8) begin bad++; $display("FAIL store_cnt got=%0d want=8", stall_cycles); end
    endtask

    task automatic test_misalign();
        do_reset();
        set_load(32'h102);
        dmem_req_ready = 1'b1;
        #1;
        total++; if ({dmem_req_valid, Stall_M, misalign_M} !== 3'b001) begin bad++; $display("FAIL mis_load got=%b want=001", {dmem_req_valid, Stall_M, misalign_M}); end
        tick();
        set_nop();
        MemWrite_M     = 1'b1;
        ALUResult_M    = 32'h201;
        dmem_req_ready = 1'b1;
        #1;
        total++; if ({dmem_req_valid, Stall_M, misalign_M} !== 3'b001) begin bad++; $display("FAIL mis_store got=%b want=001", {dmem_req_valid, Stall_M, misalign_M}); end
        tick();
        set_nop();
        tick();
        tick();
        total++; if ({misalign_err, misalign_M} !== 2'b10) begin bad++; $display("FAIL mis_sticky got=%b want=10", {misalign_err, misalign_M}); end
        total++; if (stall_cycles !== 32'd0) begin bad++; $display("FAIL mis_cnt got=%0d want=0", stall_cycles); end
        do_reset();
        total++; if (misalign_err !== 1'b0) begin bad++; $display("FAIL mis_clear got=%b want=0", misalign_err); end
    endtask

    task automatic test_reset_wait();
        do_reset();
        set_load(32'h40);
        dmem_req_ready = 1'b1;
        tick();
        #1;
        total++; if ({Stall_M, dmem_req_valid} !== 2'b10) begin bad++; $display("FAIL rw_wait got=%b want=10", {Stall_M, dmem_req_valid}); end
        set_nop();
        rst = 1'b0;
        tick();
        rst = 1'b1;
        dmem_rsp_valid = 1'b1;
        dmem_rsp_rdata = 32'h55555555;
        #1;
        total++; if (Stall_M !== 1'b0) begin bad++; $display("FAIL rw_stall got=%b want=0", Stall_M); end
        tick();
        dmem_rsp_valid = 1'b0;
        tick();
        total++; if (ReadData_M !== 32'd0) begin bad++; $display("FAIL rw_rdata got=%h want=0", ReadData_M); end
        total++; if (stall_cycles !== 32'd0) begin bad++; $display("FAIL rw_cnt got=%0d want=0", stall_cycles); end
    endtask

    task automatic test_back_to_back();
        do_reset();
        set_load(32'h0);
        dmem_req_ready = 1'b1;
        tick();
        dmem_req_ready = 1'b0;
        dmem_rsp_valid = 1'b1;
        dmem_rsp_rdata = 32'h11;
        exp_q.push_back(32'h11);
        tick();
        // DONE cycle: a stray response here must be ignored.
        dmem_rsp_rdata = 32'h99;
        #1;
        exp_v = exp_q.pop_front();
        total++; if (ReadData_M !== exp_v) begin bad++; $display("FAIL b2b_first got=%h want=%h", ReadData_M, exp_v); end
        total++; if (Stall_M !== 1'b0) begin bad++; $display("FAIL b2b_done_stall got=%b want=0", Stall_M); end
        tick();
        dmem_rsp_valid = 1'b0;
        set_load(32'h4);
        dmem_req_ready = 1'b1;
        #1;
        total++; if ({dmem_req_valid, Stall_M} !== 2'b11 || dmem_addr !== 32'h4) begin bad++; $display("FAIL b2b_second_req got=%b/%h want=11/4", {dmem_req_valid, Stall_M}, dmem_addr); end
        total++; if (ReadData_M !== 32'h11) begin bad++; $display("FAIL b2b_spur_done got=%h want=11", ReadData_M); end
        tick();
        dmem_req_ready = 1'b0;
        dmem_rsp_valid = 1'b1;
        dmem_rsp_rdata = 32'h22;
        exp_q.push_back(32'h22);
        tick();
        dmem_rsp_valid = 1'b0;
        #1;
        exp_v = exp_q.pop_front();
        total++; if (ReadData_M !== exp_v) begin bad++; $display("FAIL b2b_second got=%h want=%h", ReadData_M, exp_v); end
        tick();
        set_nop();
        tick();
        total++; if (stall_cycles !== 32'd4) begin bad++; $display("FAIL b2b_cnt got=%0d want=4", stall_cycles); end
    endtask

    // Runs after test_back_to_back, so ReadData_M should be 0x22.
    task automatic test_spurious();
        set_nop();
        exp_q.push_back(32'h22);
        dmem_rsp_valid = 1'b1;
        dmem_rsp_rdata = 32'hFFFFFFFF;
        #1;
        total++; if ({Stall_M, dmem_req_valid} !== 2'b00) begin bad++; $display("FAIL spur_stall got=%b want=00", {Stall_M, dmem_req_valid}); end
        tick();
        dmem_rsp_valid = 1'b0;
        tick();
        exp_v = exp_q.pop_front();
        total++; if (ReadData_M !== exp_v) begin bad++; $display("FAIL spur_rdata got=%h want=%h", ReadData_M, exp_v); end
        total++; if (stall_cycles !== 32'd4) begin bad++; $display("FAIL spur_cnt got=%0d want=4", stall_cycles); end
    endtask

    task automatic test_saturation();
        do_reset();
        set_load(32'h80);
        for (int i = 0; i < 10; i++) tick();
        total++; if (s_stall_cycles !== 3'd7) begin bad++; $display("FAIL sat_hold got=%0d want=7", s_stall_cycles); end
        total++; if (stall_cycles !== 32'd10) begin bad++; $display("FAIL sat_wide got=%0d want=10", stall_cycles); end
        tick();
        total++; if (s_stall_cycles !== 3'd7) begin bad++; $display("FAIL sat_stay got=%0d want=7", s_stall_cycles); end
        do_reset();
    endtask

    initial begin
        rst = 1'b0;
        set_nop();
        test_reset();
        test_load();
        test_store();
        test_misalign();
        test_reset_wait();
        test_back_to_back();
        test_spurious();
        test_saturation();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
